ddr5_request_queue: RTL and testbench

Synthesizable, parametrised request queue for the DDR5 memory scheduler. It replaces the behavioural trace-push/queue functions. It accepts CPU requests over a valid/ready handshake and decodes each address into DDR5 fields at entry. It holds up to `DEPTH` requests in strict age order, exposes every entry to the scheduler, and lets the scheduler retire any single entry per cycle with order-preserving compaction. Per-entry age counters drive a starvation flag.

---
 rtl/ddr5_sched_pkg.sv | 45 ++++
 rtl/ddr5_request_queue_if.sv | 40 ++++
 rtl/ddr5_addr_map.sv | 21 ++
 rtl/ddr5_request_queue.sv | 106 ++++++++++
 tb/tb_ddr5_request_queue.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ddr5_sched_pkg.sv
// Shared types for the DDR5 scheduler: request opcode, decoded address
// fields, the queued request record and the address bit-field positions.
package ddr5_sched_pkg;

  localparam int PKG_CYC_W  = 64;
  localparam int PKG_CORE_W = 4;
  localparam int PKG_AGE_W  = 10;

  // Physical address bit positions of each DDR5 field.
  localparam int ROW_MSB   = 33;
  localparam int ROW_LSB   = 18;
  localparam int COLH_MSB  = 17;
  localparam int COLH_LSB  = 12;
  localparam int BANK_MSB  = 11;
  localparam int BANK_LSB  = 10;
  localparam int BG_MSB    = 9;
  localparam int BG_LSB    = 7;
  localparam int CHAN_BIT  = 6;
  localparam int COLL_MSB  = 5;
  localparam int COLL_LSB  = 2;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef struct packed {
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        chan;
  } mapped_addr_t;

  typedef struct packed {
    logic [PKG_CYC_W-1:0]  cycles;
    logic [PKG_CORE_W-1:0] core;
    op_e                   op;
    mapped_addr_t          map;
    logic [PKG_AGE_W-1:0]  age;
  } req_t;

endpackage

// File: rtl/ddr5_request_queue_if.sv
// Request-queue bus: CPU push handshake, scheduler retire port and the
// full queue view. master = CPU/scheduler side, slave = the queue.
interface ddr5_request_queue_if
  import ddr5_sched_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 34,
  parameter int CORE_W = PKG_CORE_W,
  parameter int CYC_W  = PKG_CYC_W
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [CYC_W-1:0]  in_cycles;
  logic [CORE_W-1:0] in_core;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic              rm_en;
  logic [IDX_W-1:0]  rm_idx;
  req_t [DEPTH-1:0]  q_entry;
  logic [DEPTH-1:0]  q_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              starve;
  logic              err_op;

  modport master (
    output in_valid, in_cycles, in_core, in_op, in_addr, rm_en, rm_idx,
    input  in_ready, q_entry, q_valid, count, full, empty, starve, err_op
  );

  modport slave (
    input  in_valid, in_cycles, in_core, in_op, in_addr, rm_en, rm_idx,
    output in_ready, q_entry, q_valid, count, full, empty, starve, err_op
  );

endinterface

// File: rtl/ddr5_addr_map.sv
// Combinational physical-address to DDR5 field decode. Bits [1:0] are
// below burst granularity and carry no information.
module ddr5_addr_map
  import ddr5_sched_pkg::*;
#(
  parameter int ADDR_W = 34
) (
  input  logic [ADDR_W-1:0] i_addr,
  output mapped_addr_t      o_map
);

  logic w_unused;

  assign o_map.row  = i_addr[ROW_MSB:ROW_LSB];
  assign o_map.col  = {i_addr[COLH_MSB:COLH_LSB], i_addr[COLL_MSB:COLL_LSB]};
  assign o_map.bank = i_addr[BANK_MSB:BANK_LSB];
  assign o_map.bg   = i_addr[BG_MSB:BG_LSB];
  assign o_map.chan = i_addr[CHAN_BIT];
  assign w_unused   = ^i_addr[COLL_LSB-1:0];

endmodule

// File: rtl/ddr5_request_queue.sv
// Age-ordered DDR5 request queue. Slot 0 is the oldest; retiring any slot
// compacts the slots above it down by one. A single occupancy counter
// defines which slots are valid, so there are no read/write pointers.
module ddr5_request_queue
  import ddr5_sched_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 34,
  parameter int CORE_W       = PKG_CORE_W,
  parameter int CYC_W        = PKG_CYC_W,
  parameter int AGE_W        = PKG_AGE_W,
  parameter int STARVE_LIMIT = 500
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ddr5_request_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  req_t [DEPTH-1:0] r_entry;
  logic [CNT_W-1:0] r_count;
  logic             r_err_op;

  req_t [DEPTH-1:0] w_up;
  req_t [DEPTH-1:0] w_entry_nxt;
  req_t             w_new;
  mapped_addr_t     w_map;
  logic             w_hs;
  logic             w_push;
  logic             w_rm;
  logic [CNT_W-1:0] w_keep;
  logic [DEPTH-1:0] w_q_valid;

  // Saturating age increment so very old entries stay flagged as old.
  function automatic logic [PKG_AGE_W-1:0] age_inc(input logic [PKG_AGE_W-1:0] a);
    return (a == '1) ? a : a + PKG_AGE_W'(1);
  endfunction

  ddr5_addr_map #(.ADDR_W(ADDR_W)) u_map (
    .i_addr (bus.in_addr),
    .o_map  (w_map)
  );

  assign w_hs   = bus.in_valid && bus.in_ready;
  assign w_push = w_hs && (bus.in_op != 2'd3);
  assign w_rm   = bus.rm_en && (CNT_W'(bus.rm_idx) < r_count);
  // Entries that survive this edge; a push lands right after them.
  assign w_keep = r_count - CNT_W'(w_rm);

  assign w_new.cycles = bus.in_cycles;
  assign w_new.core   = bus.in_core;
  assign w_new.op     = op_e'(bus.in_op);
  assign w_new.map    = w_map;
  assign w_new.age    = '0;

  // Slot j's upper neighbour; the top slot has none and keeps itself.
  assign w_up = {r_entry[DEPTH-1], r_entry[DEPTH-1:1]};

  // Next slot contents: compact above the retired slot, age survivors, insert push.
  always_comb begin
    w_entry_nxt = r_entry;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rm && (i >= int'(bus.rm_idx))) begin
        w_entry_nxt[i] = w_up[i];
      end
      if (i < int'(w_keep)) begin
        w_entry_nxt[i].age = age_inc(w_entry_nxt[i].age);
      end
      if (w_push && (i == int'(w_keep))) begin
        w_entry_nxt[i] = w_new;
      end
    end
  end

  // Queue state registers; reset clears every slot and the counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_entry  <= '0;
      r_count  <= '0;
      r_err_op <= 1'b0;
    end else begin
      r_entry  <= w_entry_nxt;
      r_count  <= w_keep + CNT_W'(w_push);
      r_err_op <= w_hs && (bus.in_op == 2'd3);
    end
  end

  // Thermometer valid mask decoded from the registered count.
  always_comb begin
    w_q_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_q_valid[i] = (i < int'(r_count));
    end
  end

  assign bus.q_entry  = r_entry;
  assign bus.q_valid  = w_q_valid;
  assign bus.count    = r_count;
  assign bus.full     = (r_count == CNT_W'(DEPTH));
  assign bus.empty    = (r_count == '0);
  assign bus.in_ready = !bus.full;
  assign bus.err_op   = r_err_op;
  assign bus.starve   = w_q_valid[0] && (32'(r_entry[0].age) >= STARVE_LIMIT);

endmodule

// File: tb/tb_ddr5_request_queue.sv
// Directed bench for ddr5_request_queue: push/decode, fill, compaction,
// simultaneous push+retire, async reset, starvation and illegal-op drop.
module tb_ddr5_request_queue;
  import ddr5_sched_pkg::*;

  localparam int DEPTH = 16;
  localparam logic [33:0] ADDR_A = 34'h1_2345_6780;

  logic clock;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  ddr5_request_queue_if #(.DEPTH(DEPTH), .ADDR_W(34)) bus ();

  ddr5_request_queue #(
    .DEPTH(DEPTH), .ADDR_W(34), .STARVE_LIMIT(500)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One fully specified cycle of inputs, then advance past the edge.
  task automatic drive(input logic v, input logic [1:0] op, input logic [63:0] cyc,
                       input logic [33:0] addr, input logic rm, input logic [3:0] idx);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_cycles = cyc;
    bus.in_core   = cyc[3:0];
    bus.in_addr   = addr;
    bus.rm_en     = rm;
    bus.rm_idx    = idx;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_cycles = '0;
    bus.in_core   = '0;
    bus.in_addr   = '0;
    bus.rm_en     = 1'b0;
    bus.rm_idx    = '0;
    repeat (2) step();

    chk("rst_count",    64'(bus.count), 0);
    chk("rst_qvalid",   64'(bus.q_valid), 0);
    chk("rst_full",     64'(bus.full), 0);
    chk("rst_empty",    64'(bus.empty), 1);
    chk("rst_ready",    64'(bus.in_ready), 1);
    chk("rst_starve",   64'(bus.starve), 0);
    chk("rst_err",      64'(bus.err_op), 0);
    chk("rst_entry0",   64'(bus.q_entry[0].cycles), 0);
    reset_n = 1'b1;

    // Three pushes, one per cycle, all to the same address.
    drive(1, 2'd0, 10, ADDR_A, 0, 0);
    drive(1, 2'd0, 20, ADDR_A, 0, 0);
    drive(1, 2'd0, 30, ADDR_A, 0, 0);
    chk("p3_count", 64'(bus.count), 3);
    chk("p3_row",   64'(bus.q_entry[0].map.row), 64'h48D1);
    chk("p3_col",   64'(bus.q_entry[0].map.col), 64'h160);
    chk("p3_bank",  64'(bus.q_entry[0].map.bank), 1);
    chk("p3_bg",    64'(bus.q_entry[0].map.bg), 7);
    chk("p3_chan",  64'(bus.q_entry[0].map.chan), 0);
    chk("p3_age0",  64'(bus.q_entry[0].age), 2);
    chk("p3_age2",  64'(bus.q_entry[2].age), 0);
    chk("p3_cyc2",  64'(bus.q_entry[2].cycles), 30);

    // Fill to capacity.
    for (int k = 4; k <= 16; k++) drive(1, 2'd1, 64'(10 * k), 34'(k << 2), 0, 0);
    chk("fill_count", 64'(bus.count), 16);
    chk("fill_full",  64'(bus.full), 1);
    chk("fill_ready", 64'(bus.in_ready), 0);
    chk("fill_qv",    64'(bus.q_valid), 64'hFFFF);

    // 17th push held while full must not land.
    drive(1, 2'd0, 999, 34'h0, 0, 0);
    chk("ovf_count", 64'(bus.count), 16);
    chk("ovf_cyc15", 64'(bus.q_entry[15].cycles), 160);
    chk("ovf_cyc0",  64'(bus.q_entry[0].cycles), 10);

    // Retire while full with a push offered: removal only.
    drive(1, 2'd0, 170, 34'h0, 1, 0);
    chk("rmf_count", 64'(bus.count), 15);
    chk("rmf_cyc0",  64'(bus.q_entry[0].cycles), 20);
    chk("rmf_cyc14", 64'(bus.q_entry[14].cycles), 160);
    chk("rmf_ready", 64'(bus.in_ready), 1);
    drive(1, 2'd0, 170, 34'h0, 0, 0);
    chk("rmf2_count", 64'(bus.count), 16);
    chk("rmf2_cyc15", 64'(bus.q_entry[15].cycles), 170);
    chk("rmf2_age15", 64'(bus.q_entry[15].age), 0);

    // Asynchronous reset mid-stream clears without waiting for an edge.
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count", 64'(bus.count), 0);
    chk("ar_qv",    64'(bus.q_valid), 0);
    chk("ar_empty", 64'(bus.empty), 1);
    chk("ar_cyc0",  64'(bus.q_entry[0].cycles), 0);
    step();
    reset_n = 1'b1;

    // Five entries A..E (cycles 1..5), retire slot 2.
    for (int k = 1; k <= 5; k++) drive(1, 2'd2, 64'(k), 34'h0, 0, 0);
    drive(0, 2'd0, 0, 34'h0, 1, 2);
    chk("c_count", 64'(bus.count), 4);
    chk("c_s0",    64'(bus.q_entry[0].cycles), 1);
    chk("c_s1",    64'(bus.q_entry[1].cycles), 2);
    chk("c_s2",    64'(bus.q_entry[2].cycles), 4);
    chk("c_s3",    64'(bus.q_entry[3].cycles), 5);
    chk("c_age0",  64'(bus.q_entry[0].age), 5);
    chk("c_age3",  64'(bus.q_entry[3].age), 1);
    drive(0, 2'd0, 0, 34'h0, 1, 7);
    chk("oob_count", 64'(bus.count), 4);
    chk("oob_s2",    64'(bus.q_entry[2].cycles), 4);

    // Retire slot 1 and push X on the same edge.
    drive(1, 2'd0, 77, 34'h0, 1, 1);
    chk("rp_count", 64'(bus.count), 4);
    chk("rp_s1",    64'(bus.q_entry[1].cycles), 4);
    chk("rp_s2",    64'(bus.q_entry[2].cycles), 5);
    chk("rp_s3",    64'(bus.q_entry[3].cycles), 77);
    chk("rp_age3",  64'(bus.q_entry[3].age), 0);

    // Starvation: single entry aged past the limit, then to saturation.
    bus.in_valid = 1'b0;
    bus.rm_en    = 1'b0;
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(1, 2'd0, 42, ADDR_A, 0, 0);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 1030; k++) begin
      step();
      if (k >= 495 && k <= 505) chk($sformatf("starve_%0d", k), 64'(bus.starve), 64'(k >= 500));
      if (k == 500) chk("age_500", 64'(bus.q_entry[0].age), 500);
    end
    chk("age_sat",    64'(bus.q_entry[0].age), 1023);
    chk("starve_sat", 64'(bus.starve), 1);

    // Illegal op is consumed, not stored, and pulses err_op once.
    drive(1, 2'd3, 5, 34'h0, 0, 0);
    chk("err_pulse", 64'(bus.err_op), 1);
    chk("err_count", 64'(bus.count), 1);
    drive(0, 2'd0, 0, 34'h0, 0, 0);
    chk("err_clear", 64'(bus.err_op), 0);
    chk("err_count2", 64'(bus.count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
